// File: rtl/buffer_entrada.sv
// buffer_entrada: input-port FIFO and XY requester for one mesh router port.
// Single-flit packets are queued, the head flit is routed XY, and a one-hot
// request is held toward the output arbiters until the matching grant arrives.
// Optional wait-cycle counter (espera/fome) is built only when the macro
// BUFFER_ENTRADA_ESPERA_EN is defined; otherwise both outputs are tied to 0.
//
// state     | meaning
// OCIOSO    | no request; waiting for the FIFO to hold a flit
// ROTEIA    | capture the XY direction of the head flit
// REQUISITA | hold req = dir until a grant bit inside dir arrives
module buffer_entrada #(
    parameter int FLIT_W  = 16,
    parameter int COORD_W = 2,
    parameter int PROF    = 4,
    parameter int X_LOCAL = 0,
    parameter int Y_LOCAL = 0,
    parameter int LIMITE  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FLIT_W-1:0] in_data,
    output logic [4:0]        req,
    input  logic [4:0]        grant,
    output logic              out_valid,
    output logic [FLIT_W-1:0] out_data,
    output logic [7:0]        espera,
    output logic              fome
);

    localparam int PTR_W = $clog2(PROF);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_CHEIO = CNT_W'(PROF);
    localparam logic [CNT_W-1:0] CNT_UM    = CNT_W'(1);

    localparam logic [4:0] DIR_CIMA     = 5'b10000;
    localparam logic [4:0] DIR_BAIXO    = 5'b01000;
    localparam logic [4:0] DIR_ESQUERDA = 5'b00100;
    localparam logic [4:0] DIR_DIREITA  = 5'b00010;
    localparam logic [4:0] DIR_LOCAL    = 5'b00001;

    typedef enum logic [1:0] {
        OCIOSO    = 2'd0,
        ROTEIA    = 2'd1,
        REQUISITA = 2'd2
    } estado_t;

    estado_t estado, estado_nxt;

    logic [FLIT_W-1:0] mem [PROF];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [4:0]        dir;
    logic              push, pop, transfer;
    logic              cheio;

    // XY routing: resolve X first, then Y, otherwise deliver locally
    function automatic logic [4:0] calc_dir(input logic [FLIT_W-1:0] f);
        logic [COORD_W-1:0] dx;
        logic [COORD_W-1:0] dy;
        logic [4:0]         d;
        dx = f[FLIT_W-1 -: COORD_W];
        dy = f[FLIT_W-1-COORD_W -: COORD_W];
        if (int'(dx) > X_LOCAL)
            d = DIR_DIREITA;
        else if (int'(dx) < X_LOCAL)
            d = DIR_ESQUERDA;
        else if (int'(dy) > Y_LOCAL)
            d = DIR_CIMA;
        else if (int'(dy) < Y_LOCAL)
            d = DIR_BAIXO;
        else
            d = DIR_LOCAL;
        return d;
    endfunction

    // ready looks only at the registered count, so a pop never frees a slot
    // for a push in the same cycle
    assign cheio    = (count == CNT_CHEIO);
    assign in_ready = !cheio;
    assign push     = in_valid && in_ready;
    assign pop      = transfer;

    assign out_data  = mem[rd_ptr];
    assign out_valid = transfer;

    // flit storage; contents need no reset because count gates every read
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= in_data;
    end

    // circular pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)
                count <= count + CNT_UM;
            else if (!push && pop)
                count <= count - CNT_UM;
        end
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst)
            estado <= OCIOSO;
        else
            estado <= estado_nxt;
    end

    // direction of the head flit, captured once per flit in ROTEIA
    always_ff @(posedge clk) begin
        if (rst)
            dir <= '0;
        else if (estado == ROTEIA)
            dir <= calc_dir(mem[rd_ptr]);
    end

    // next state, request and transfer decode
    always_comb begin
        estado_nxt = estado;
        req        = '0;
        transfer   = 1'b0;
        case (estado)
            OCIOSO: begin
                if (count != '0)
                    estado_nxt = ROTEIA;
            end
            ROTEIA: begin
                estado_nxt = REQUISITA;
            end
            REQUISITA: begin
                req = dir;
                if (|(grant & dir)) begin
                    transfer   = 1'b1;
                    estado_nxt = (count > CNT_UM) ? ROTEIA : OCIOSO;
                end
            end
            default: begin
                estado_nxt = OCIOSO;
            end
        endcase
    end

`ifdef BUFFER_ENTRADA_ESPERA_EN
    logic [7:0] espera_q, espera_nxt;
    logic       fome_q;

    // wait counter: grows while requesting without a transfer, saturates
    always_comb begin
        espera_nxt = espera_q;
        if (transfer)
            espera_nxt = '0;
        else if (estado == REQUISITA && espera_q != 8'hFF)
            espera_nxt = espera_q + 8'd1;
    end

    // fome is derived from the next count so it always agrees with espera
    always_ff @(posedge clk) begin
        if (rst) begin
            espera_q <= '0;
            fome_q   <= 1'b0;
        end else begin
            espera_q <= espera_nxt;
            fome_q   <= (int'(espera_nxt) >= LIMITE);
        end
    end

    assign espera = espera_q;
    assign fome   = fome_q;
`else
    // the threshold only matters when the wait counter is built
    logic [31:0] unused_limite;
    assign unused_limite = LIMITE;
    assign espera        = '0;
    assign fome          = 1'b0;
`endif

endmodule

// File: tb/tb_buffer_entrada.sv
// Bench for buffer_entrada: directed table, hand sequences for the multi-cycle
// corners, then random traffic checked against a queue-based timing model.
module tb_buffer_entrada;

    localparam int FLIT_W = 16;
    localparam int PROF   = 4;
    localparam int XL     = 1;
    localparam int YL     = 1;
    localparam int LIM    = 16;

`ifdef BUFFER_ENTRADA_ESPERA_EN
    localparam int ESPERA_EN = 1;
`else
    localparam int ESPERA_EN = 0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [FLIT_W-1:0] in_data;
    logic [4:0]        req;
    logic [4:0]        grant;
    logic              out_valid;
    logic [FLIT_W-1:0] out_data;
    logic [7:0]        espera;
    logic              fome;

    always #5 clk = ~clk;

    buffer_entrada #(
        .FLIT_W (FLIT_W),
        .COORD_W(2),
        .PROF   (PROF),
        .X_LOCAL(XL),
        .Y_LOCAL(YL),
        .LIMITE (LIM)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .req      (req),
        .grant    (grant),
        .out_valid(out_valid),
        .out_data (out_data),
        .espera   (espera),
        .fome     (fome)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nome, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nome, act, exp);
        end
    endtask

    // reference model: queued flits, the cycle each was accepted, and the
    // cycle of the last transfer; a head flit is requested from
    // max(accept+3, last_transfer+2) onwards
    logic [FLIT_W-1:0] mq[$];
    int                tq[$];
    int                ultimo = -100;
    int                esp_m  = 0;
    int                cyc    = 0;

    function automatic logic [4:0] rota(input logic [FLIT_W-1:0] f);
        int dx;
        int dy;
        dx = int'(f[15:14]);
        dy = int'(f[13:12]);
        if (dx > XL) return 5'b00010;
        if (dx < XL) return 5'b00100;
        if (dy > YL) return 5'b10000;
        if (dy < YL) return 5'b01000;
        return 5'b00001;
    endfunction

    function automatic bit m_ativo();
        int t;
        if (mq.size() == 0) return 1'b0;
        t = (tq[0] + 3 > ultimo + 2) ? tq[0] + 3 : ultimo + 2;
        return cyc >= t;
    endfunction

    // drive one cycle of inputs, compare against the model, advance the model
    task automatic aplica(input logic r, input logic v, input logic [FLIT_W-1:0] d,
                          input logic [4:0] g, input bit com_modelo);
        bit         ativo;
        bit         xfer;
        bit         ok_in;
        logic [4:0] r_exp;
        rst      = r;
        in_valid = v;
        in_data  = d;
        grant    = g;
        #1;
        ativo = m_ativo();
        r_exp = ativo ? rota(mq[0]) : 5'b00000;
        xfer  = ativo && ((g & r_exp) != 5'b00000);
        ok_in = (mq.size() < PROF);
        if (com_modelo) begin
            chk("m_req", int'(req), int'(r_exp));
            chk("m_out_valid", int'(out_valid), int'(xfer));
            chk("m_in_ready", int'(in_ready), int'(ok_in));
            if (xfer) chk("m_out_data", int'(out_data), int'(mq[0]));
            chk("m_espera", int'(espera), ESPERA_EN ? esp_m : 0);
            chk("m_fome", int'(fome), (ESPERA_EN != 0 && esp_m >= LIM) ? 1 : 0);
        end
        if (r) begin
            mq.delete();
            tq.delete();
            ultimo = -100;
            esp_m  = 0;
        end else begin
            if (xfer) begin
                void'(mq.pop_front());
                void'(tq.pop_front());
                ultimo = cyc;
                esp_m  = 0;
            end else if (ativo && esp_m < 255) begin
                esp_m++;
            end
            if (v && ok_in) begin
                mq.push_back(d);
                tq.push_back(cyc);
            end
        end
    endtask

    task automatic passo();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    typedef struct {
        logic              v;
        logic [FLIT_W-1:0] d;
        logic [4:0]        g;
        logic [4:0]        req_e;
        logic              ov_e;
        logic              rdy_e;
        logic [FLIT_W-1:0] dado_e;
    } vec_t;

    vec_t              tab[20];
    logic [FLIT_W-1:0] fl[5] = '{16'h9A01, 16'h1B02, 16'h7C03, 16'h4D04, 16'h5E05};
    logic [4:0]        dr[5] = '{5'b00010, 5'b00100, 5'b10000, 5'b01000, 5'b00001};
    logic [FLIT_W-1:0] enviados[$];
    logic [FLIT_W-1:0] saidas[$];

    initial begin
        bit         visto;
        logic       r;
        logic [4:0] g;

        // table: one flit at a time, grant always high
        for (int i = 0; i < 5; i++) begin
            tab[4*i]   = '{1'b1, fl[i], 5'h1f, 5'b00000, 1'b0, 1'b1, 16'h0};
            tab[4*i+1] = '{1'b0, 16'h0, 5'h1f, 5'b00000, 1'b0, 1'b1, 16'h0};
            tab[4*i+2] = '{1'b0, 16'h0, 5'h1f, 5'b00000, 1'b0, 1'b1, 16'h0};
            tab[4*i+3] = '{1'b0, 16'h0, 5'h1f, dr[i],    1'b1, 1'b1, fl[i]};
        end

        rst = 1'b1; in_valid = 1'b0; in_data = '0; grant = '0;
        #2;
        aplica(1'b1, 1'b0, '0, '0, 1'b0);
        passo();

        aplica(1'b0, 1'b0, '0, '0, 1'b1);
        chk("rst_req", int'(req), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_espera", int'(espera), 0);
        chk("rst_fome", int'(fome), 0);
        passo();

        for (int i = 0; i < 20; i++) begin
            aplica(1'b0, tab[i].v, tab[i].d, tab[i].g, 1'b1);
            chk($sformatf("tab%0d_req", i), int'(req), int'(tab[i].req_e));
            chk($sformatf("tab%0d_out_valid", i), int'(out_valid), int'(tab[i].ov_e));
            chk($sformatf("tab%0d_in_ready", i), int'(in_ready), int'(tab[i].rdy_e));
            if (tab[i].ov_e) chk($sformatf("tab%0d_out_data", i), int'(out_data), int'(tab[i].dado_e));
            passo();
        end
        aplica(1'b0, 1'b0, '0, 5'h1f, 1'b1);
        chk("idle_req_after_xfer", int'(req), 0);
        passo();

        // fill with grant low: fifth flit refused, then drain in order
        enviados.delete();
        for (int i = 0; i < 5; i++) begin
            logic [FLIT_W-1:0] d;
            d = FLIT_W'($urandom);
            enviados.push_back(d);
            aplica(1'b0, 1'b1, d, 5'b00000, 1'b1);
            if (i == 4) chk("fill_in_ready_full", int'(in_ready), 0);
            passo();
        end
        saidas.delete();
        visto = 1'b0;
        for (int i = 0; i < 10; i++) begin
            aplica(1'b0, 1'b0, '0, 5'h1f, 1'b1);
            if (visto && saidas.size() == 1) chk("fill_in_ready_after_pop", int'(in_ready), 1);
            if (out_valid) saidas.push_back(out_data);
            visto = (saidas.size() > 0);
            passo();
        end
        chk("fill_count_out", saidas.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < saidas.size()) chk($sformatf("fill_order%0d", i), int'(saidas[i]), int'(enviados[i]));

        // wrong grant bits are ignored, request held
        aplica(1'b0, 1'b1, 16'h9123, 5'b00000, 1'b1); passo();
        aplica(1'b0, 1'b0, '0, 5'b00000, 1'b1); passo();
        aplica(1'b0, 1'b0, '0, 5'b00000, 1'b1); passo();
        for (int i = 0; i < 3; i++) begin
            aplica(1'b0, 1'b0, '0, 5'b10101, 1'b1);
            chk("wrong_grant_req", int'(req), 5'b00010);
            chk("wrong_grant_out_valid", int'(out_valid), 0);
            passo();
        end
        aplica(1'b0, 1'b0, '0, 5'b00010, 1'b1);
        chk("right_grant_out_valid", int'(out_valid), 1);
        chk("right_grant_out_data", int'(out_data), 16'h9123);
        passo();

        // reset while requesting with three flits queued
        for (int i = 0; i < 3; i++) begin
            aplica(1'b0, 1'b1, 16'h9000 + FLIT_W'(i), 5'b00000, 1'b1);
            passo();
        end
        aplica(1'b0, 1'b0, '0, 5'b00000, 1'b1);
        chk("pre_rst_req", int'(req), 5'b00010);
        passo();
        aplica(1'b1, 1'b0, '0, 5'b00000, 1'b1);
        passo();
        aplica(1'b0, 1'b0, '0, 5'b00000, 1'b1);
        chk("post_rst_req", int'(req), 0);
        chk("post_rst_in_ready", int'(in_ready), 1);
        passo();
        for (int i = 0; i < 5; i++) begin
            aplica(1'b0, 1'b0, '0, 5'h1f, 1'b1);
            chk("post_rst_no_xfer", int'(out_valid), 0);
            passo();
        end

        // wait counter: 20 ungranted request cycles, then grant
        aplica(1'b0, 1'b1, 16'h5777, 5'b00000, 1'b1); passo();
        aplica(1'b0, 1'b0, '0, 5'b00000, 1'b1); passo();
        aplica(1'b0, 1'b0, '0, 5'b00000, 1'b1); passo();
        for (int i = 0; i < 20; i++) begin
            aplica(1'b0, 1'b0, '0, 5'b00000, 1'b1);
            passo();
        end
        aplica(1'b0, 1'b0, '0, 5'h1f, 1'b1);
        chk("espera_20", int'(espera), ESPERA_EN ? 20 : 0);
        chk("fome_20", int'(fome), ESPERA_EN ? 1 : 0);
        chk("espera_grant_xfer", int'(out_valid), 1);
        passo();
        aplica(1'b0, 1'b0, '0, 5'b00000, 1'b1);
        chk("espera_cleared", int'(espera), 0);
        chk("fome_cleared", int'(fome), 0);
        passo();

        // random traffic with periodic grant droughts and rare resets
        for (int i = 0; i < 1500; i++) begin
            r = ($urandom_range(0, 199) == 0);
            g = ($urandom_range(0, 2) == 0) ? 5'h1f : 5'($urandom);
            if ($urandom_range(0, 9) < 2) g = 5'b00000;
            if ((i % 300) < 40) g = 5'b00000;
            aplica(r, 1'($urandom), FLIT_W'($urandom), g, 1'b1);
            passo();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/buffer_entrada.md
# buffer_entrada

Input-port buffer and requester for the mesh router. It accepts single-flit packets from a link or the local core into a FIFO, computes the XY-routed output direction of the head flit, and drives a one-hot request toward the five output-port arbiters. It holds that request until the addressed arbiter grants it, then presents the flit for exactly one cycle. It is the requesting end of the `req`/`grant` protocol served by the fixed-priority arbiters.

## Interface
- `FLIT_W`, 16, flit width; destination coordinates in the top bits
- `COORD_W`, 2, width of each X/Y coordinate
- `PROF`, 4, FIFO depth in flits (power of two, ≥2)
- `X_LOCAL`, 0, X coordinate of this router
- `Y_LOCAL`, 0, Y coordinate of this router
- `LIMITE`, 16, wait-cycle threshold for `fome` (see Configuration)

- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, synchronous, active-high
- `in_valid`  in  1  upstream flit valid
- `in_ready`  out  1  buffer can accept (`!cheio`)
- `in_data`  in  FLIT_W  upstream flit
- `req`  out  5  one-hot request: [4] CIMA, [3] BAIXO, [2] ESQUERDA, [1] DIREITA, [0] LOCAL
- `grant`  in  5  grant bit for this input from each output arbiter, same bit order
- `out_valid`  out  1  flit transferred this cycle
- `out_data`  out  FLIT_W  head flit
- `espera`  out  8  cycles spent requesting without grant
- `fome`  out  1  `espera >= LIMITE`

## Operation
- Destination X = `in_data[FLIT_W-1 -: COORD_W]`; destination Y = the next `COORD_W` bits below X. Both are unsigned.
- XY routing of the head flit, evaluated in order:
  - dest X > `X_LOCAL` → DIREITA
  - dest X < `X_LOCAL` → ESQUERDA
  - dest Y > `Y_LOCAL` → CIMA
  - dest Y < `Y_LOCAL` → BAIXO
  - otherwise → LOCAL
- FIFO: circular, with `PROF` entries, pointers of log2(PROF) bits that wrap, and a count of log2(PROF)+1 bits.
  - Push when `in_valid && in_ready`.
  - `in_ready` depends only on the registered count, so no push happens when full, even in a cycle that pops.
- FSM states:
  - OCIOSO: `req`=0. Go to ROTEIA when the FIFO is non-empty.
  - ROTEIA: register `dir` from the head flit. Go to REQUISITA.
  - REQUISITA: `req`=`dir`, held stable.
    - Transfer occurs when `|(grant & dir)`: `out_valid`=1, pop, then go to ROTEIA if count>1, else OCIOSO.
    - Grant bits outside `dir` are ignored.
- `out_data` always shows the FIFO head. It is only meaningful when `out_valid`=1.
- `out_valid` = transfer. It is combinational from `grant`, so the arbiter chain must be registered downstream.

## Timing
- Reset values, all applied at the edge where `rst`=1:
  - pointers=0, count=0, state OCIOSO, `dir`=0, `espera`=0
  - `req`=0, `out_valid`=0, `in_ready`=1, `fome`=0
- Reset mid-request: `req` drops after that edge and FIFO contents are discarded.
- Latency into an empty buffer:
  - flit pushed at edge N
  - state becomes ROTEIA at N+1
  - `req` asserts after edge N+2
  - earliest `out_valid` is in cycle N+2..N+3 (same cycle as the grant)
- Throughput: one flit per 2 cycles under continuous grant, because ROTEIA is inserted between consecutive flits.
- Simultaneous push and pop: the count is unchanged and both pointers advance.
- `req` never changes while in REQUISITA until a transfer occurs.

## Configuration
- `BUFFER_ENTRADA_ESPERA_EN` defined:
  - `espera` increments every cycle in REQUISITA without a transfer, saturating at 255.
  - It clears on transfer and on reset.
  - `fome` = `espera >= LIMITE`, registered.
- Not defined: `espera`=0 and `fome`=0 constantly, with no counter logic. Ports remain present.

## Test plan
- X_LOCAL=1, Y_LOCAL=1, COORD_W=2, FLIT_W=16, PROF=4. Push flits with dest (2,1), (0,1), (1,3), (1,0), (1,1), each granted in the same cycle as its request → `req` = 00010, 00100, 10000, 01000, 00001 respectively, each with `out_valid` and the matching `out_data`.
- Push one flit at edge N with `grant`=11111 → `req` rises after N+2, `out_valid`=1 in that cycle, state returns to OCIOSO, `req`=0 afterwards.
- Hold `grant`=0 and push 5 flits → the first 4 are accepted and `in_ready`=0 after the 4th. Then grant 4 times → flits come out in order and `in_ready` returns to 1 after the first pop.
- Request DIREITA while driving `grant`=10101 (wrong bits) → no transfer and `req` is held. Then `grant`=00010 → transfer.
- Assert `rst` while in REQUISITA with 3 flits queued → after that edge `req`=0, `in_ready`=1, and a subsequent `grant`=11111 yields no `out_valid`.
- With `BUFFER_ENTRADA_ESPERA_EN` and LIMITE=16, request with `grant`=0 for 20 cycles → `espera` reaches 20 and `fome`=1. Grant → `espera`=0 and `fome`=0 on the next cycle. With the macro undefined, the same stimulus gives `espera`=0 and `fome`=0.
